// File: rtl/div_unit_pkg.sv
// Shared RV32M divide-class encodings and opcode decode helpers for div_unit.
package div_unit_pkg;

   localparam int         REG_ADDR_W = 5;
   localparam logic [2:0] INST_DIV   = 3'b100;
   localparam logic [2:0] INST_DIVU  = 3'b101;
   localparam logic [2:0] INST_REM   = 3'b110;
   localparam logic [2:0] INST_REMU  = 3'b111;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == INST_DIV) || (op == INST_DIVU) || (op == INST_REM) || (op == INST_REMU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == INST_DIV) || (op == INST_REM);
   endfunction

   function automatic logic is_rem_op(input logic [2:0] op);
      return (op == INST_REM) || (op == INST_REMU);
   endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign fix-up on the way into END, one-cycle result strobe with the captured rd.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [XLEN-1:0]       dividend_i,
   input  logic [XLEN-1:0]       divisor_i,
   input  logic [REG_ADDR_W-1:0] reg_waddr_i,
   input  logic                  cancel_i,
   output logic                  busy_o,
   output logic                  ready_o,
   output logic [XLEN-1:0]       result_o,
   output logic [REG_ADDR_W-1:0] reg_waddr_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_END  = 2'b10
   } state_e;

   localparam int             CW         = $clog2(XLEN);
   localparam logic [CW-1:0]  LAST_COUNT = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] DIV_ZERO_QUOT = {XLEN{1'b1}};

   function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] v);
      return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? neg_val(v) : v;
   endfunction

   state_e                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [2:0]            op_q, op_d;
   logic                  quot_neg_q, quot_neg_d;
   logic                  rem_neg_q, rem_neg_d;
   logic [XLEN-1:0]       dvd_q, dvd_d;
   logic [XLEN-1:0]       dsr_q, dsr_d;
   logic [XLEN-1:0]       rem_q, rem_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;
   logic [XLEN-1:0]       result_q, result_d;
   logic [REG_ADDR_W-1:0] waddr_q, waddr_d;

   logic [XLEN:0]         trial_s;
   logic [XLEN:0]         diff_s;
   logic                  qbit_s;
   logic [XLEN-1:0]       next_rem_s;
   logic [XLEN-1:0]       next_quot_s;
   logic                  signed_s;

   // Remainder stays below the divisor, so the XLEN+1-bit difference's MSB is a clean borrow.
   always_comb begin
      trial_s     = {rem_q, dvd_q[XLEN-1]};
      diff_s      = trial_s - {1'b0, dsr_q};
      qbit_s      = ~diff_s[XLEN];
      next_rem_s  = qbit_s ? diff_s[XLEN-1:0] : trial_s[XLEN-1:0];
      next_quot_s = {dvd_q[XLEN-2:0], qbit_s};
   end

   // Next-state, datapath and registered-output values.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      op_d       = op_q;
      quot_neg_d = quot_neg_q;
      rem_neg_d  = rem_neg_q;
      dvd_d      = dvd_q;
      dsr_d      = dsr_q;
      rem_d      = rem_q;
      busy_d     = busy_q;
      ready_d    = 1'b0;
      result_d   = {XLEN{1'b0}};
      waddr_d    = waddr_q;
      signed_s   = is_signed_op(op_i);
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start_i && !cancel_i && is_div_op(op_i)) begin
               op_d       = op_i;
               waddr_d    = reg_waddr_i;
               quot_neg_d = signed_s & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
               rem_neg_d  = signed_s & dividend_i[XLEN-1];
               dvd_d      = magnitude(dividend_i, signed_s);
               dsr_d      = magnitude(divisor_i, signed_s);
               rem_d      = {XLEN{1'b0}};
               count_d    = {CW{1'b0}};
               busy_d     = 1'b1;
               if (divisor_i == {XLEN{1'b0}}) begin
                  state_d  = S_END;
                  ready_d  = 1'b1;
                  result_d = is_rem_op(op_i) ? dividend_i : DIV_ZERO_QUOT;
               end else begin
                  state_d = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (cancel_i) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               dvd_d   = next_quot_s;
               rem_d   = next_rem_s;
               count_d = count_q + CW'(1'b1);
               if (count_q == LAST_COUNT) begin
                  state_d = S_END;
                  ready_d = 1'b1;
                  if (is_rem_op(op_q)) begin
                     result_d = rem_neg_q ? neg_val(next_rem_s) : next_rem_s;
                  end else begin
                     result_d = quot_neg_q ? neg_val(next_quot_s) : next_quot_s;
                  end
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_END: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= {CW{1'b0}};
         op_q       <= 3'b000;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         dvd_q      <= {XLEN{1'b0}};
         dsr_q      <= {XLEN{1'b0}};
         rem_q      <= {XLEN{1'b0}};
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         result_q   <= {XLEN{1'b0}};
         waddr_q    <= ZERO_REG;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         op_q       <= op_d;
         quot_neg_q <= quot_neg_d;
         rem_neg_q  <= rem_neg_d;
         dvd_q      <= dvd_d;
         dsr_q      <= dsr_d;
         rem_q      <= rem_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         result_q   <= result_d;
         waddr_q    <= waddr_d;
      end
   end

   assign busy_o      = busy_q;
   assign ready_o     = ready_q;
   assign result_o    = result_q;
   assign reg_waddr_o = waddr_q;

endmodule
